// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the multi-cycle MUL/DIV sequencer: ALU opcodes,
// controller FSM states and command values.
package alu_seq_ctrl_pkg;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b0101;
    localparam logic [3:0] ALU_MOV = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SLR = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        CMD_MULU = 1'b0,
        CMD_DIVU = 1'b1
    } cmd_t;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Request/result handshake plus the time-shared ALU port of the sequencer.
// slave = the sequencer; master = execute stage and the ALU it borrows.
interface alu_seq_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             cmd;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             zero;
    logic             div0;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_op;
    logic [3:0]       alu_shift_d;
    logic [WIDTH-1:0] alu_res;

    modport master (
        output start, cmd, opa, opb, alu_res,
        input  busy, done, res_hi, res_lo, zero, div0,
               alu_own, alu_a, alu_b, alu_op, alu_shift_d
    );

    modport slave (
        input  start, cmd, opa, opb, alu_res,
        output busy, done, res_hi, res_lo, zero, div0,
               alu_own, alu_a, alu_b, alu_op, alu_shift_d
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Unsigned 16x16 MUL (shift-add) and 16/16 DIV (restoring) sequencer that
// borrows the shared ALU for one iteration per cycle.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_seq_ctrl_if.slave bus
);

    state_t           state_q, state_d;
    cmd_t             cmd_q;
    logic [WIDTH-1:0] opnd_q;   // multiplicand or divisor, stable through ITER
    logic [WIDTH-1:0] acc_q;    // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0] mq_q;     // MUL multiplier bits / DIV quotient bits
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_hi_q, res_lo_q;
    logic             zero_q, div0_q;

    logic             accept, div_by_zero, last_iter;
    logic [WIDTH:0]   div_sh, mul_sum;
    logic             div_ge;
    logic [WIDTH-1:0] acc_d, mq_d;

    assign accept      = (state_q == ST_IDLE) && bus.start;
    assign div_by_zero = (bus.cmd == CMD_DIVU) && (bus.opb == '0);
    assign last_iter   = (cnt_q == CNT_W'(WIDTH - 1));
    assign div_sh      = {acc_q, mq_q[WIDTH-1]};

    // NOTE: every signal assigned in an always_comb gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        mul_sum = '0;
        div_ge  = 1'b0;
        acc_d   = acc_q;
        mq_d    = mq_q;
        if (cmd_q == CMD_MULU) begin
            // ALU adds without reporting carry; an unsigned wrap reveals it
            mul_sum = mq_q[0] ? {(bus.alu_res < acc_q), bus.alu_res} : {1'b0, acc_q};
            acc_d   = mul_sum[WIDTH:1];
            mq_d    = {mul_sum[0], mq_q[WIDTH-1:1]};
        end else begin
            div_ge  = (div_sh >= {1'b0, opnd_q});
            acc_d   = div_ge ? bus.alu_res : div_sh[WIDTH-1:0];
            mq_d    = {mq_q[WIDTH-2:0], div_ge};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (bus.start) state_d = div_by_zero ? ST_DONE : ST_ITER;
            ST_ITER: if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = (state_q == ST_DONE);
        bus.alu_own = (state_q == ST_ITER);
        bus.alu_op  = ALU_MOV;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        if (state_q == ST_ITER) begin
            bus.alu_op = (cmd_q == CMD_MULU) ? ALU_ADD : ALU_SUB;
            bus.alu_a  = opnd_q;
            bus.alu_b  = (cmd_q == CMD_MULU) ? acc_q : div_sh[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q    <= CMD_MULU;
            opnd_q   <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else if (accept) begin
            cmd_q    <= cmd_t'(bus.cmd);
            opnd_q   <= (bus.cmd == CMD_MULU) ? bus.opa : bus.opb;
            mq_q     <= (bus.cmd == CMD_MULU) ? bus.opb : bus.opa;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_hi_q <= div_by_zero ? bus.opa : '0;
            res_lo_q <= div_by_zero ? '1 : '0;
            zero_q   <= 1'b0;
            div0_q   <= div_by_zero;
        end else if (state_q == ST_ITER) begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_iter) begin
                res_hi_q <= acc_d;
                res_lo_q <= mq_d;
                zero_q   <= (cmd_q == CMD_MULU) ? ({acc_d, mq_d} == '0) : (mq_d == '0);
            end
        end
    end

    assign bus.res_hi      = res_hi_q;
    assign bus.res_lo      = res_lo_q;
    assign bus.zero        = zero_q;
    assign bus.div0        = div0_q;
    assign bus.alu_shift_d = 4'd0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: ALU model, cycle-level reference
// model of the request/result contract, directed and randomized operations.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   chk_en = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    alu_seq_ctrl_if #(.WIDTH(16)) bus ();

    alu_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU/shifter; SUB and CMP compute b - a.
    always_comb begin
        case (bus.alu_op)
            ALU_ADD: bus.alu_res = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_res = bus.alu_b - bus.alu_a;
            ALU_AND: bus.alu_res = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_res = bus.alu_a | bus.alu_b;
            ALU_XOR: bus.alu_res = bus.alu_a ^ bus.alu_b;
            ALU_CMP: bus.alu_res = bus.alu_b - bus.alu_a;
            ALU_MOV: bus.alu_res = bus.alu_a;
            ALU_SLL: bus.alu_res = bus.alu_a << bus.alu_shift_d;
            ALU_SLR: bus.alu_res = (bus.alu_a << bus.alu_shift_d) | (bus.alu_a >> (5'd16 - {1'b0, bus.alu_shift_d}));
            ALU_SRL: bus.alu_res = bus.alu_a >> bus.alu_shift_d;
            ALU_SRA: bus.alu_res = $unsigned($signed(bus.alu_a) >>> bus.alu_shift_d);
            default: bus.alu_res = 16'h0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted request finishes after a fixed latency
    // with results computed by plain arithmetic.
    bit          m_active = 0;
    int          m_age = 0;
    int          m_lat = 0;
    bit          m_cmd = 0;
    logic [15:0] m_a = '0, m_b = '0;
    logic [15:0] e_hi = '0, e_lo = '0;
    bit          e_zero = 0, e_div0 = 0;
    logic [15:0] p_hi = '0, p_lo = '0;
    bit          p_zero = 0;
    logic [31:0] prod;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 0; m_age = 0;
            e_hi = '0; e_lo = '0; e_zero = 0; e_div0 = 0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_cmd = bus.cmd; m_a = bus.opa; m_b = bus.opb;
                m_active = 1; m_age = 1;
                e_hi = '0; e_lo = '0; e_zero = 0; e_div0 = 0;
                if (bus.cmd && bus.opb == 16'h0) begin
                    m_lat = 1;
                    e_hi = bus.opa; e_lo = 16'hFFFF; e_div0 = 1;
                end else begin
                    m_lat = 17;
                    if (!bus.cmd) begin
                        prod = 32'(bus.opa) * 32'(bus.opb);
                        p_hi = prod[31:16]; p_lo = prod[15:0];
                        p_zero = (prod == 32'h0);
                    end else begin
                        p_lo = bus.opa / bus.opb;
                        p_hi = bus.opa % bus.opb;
                        p_zero = (p_lo == 16'h0);
                    end
                end
            end
        end else if (m_age == m_lat) begin
            m_active = 0;
        end else begin
            m_age++;
            if (m_age == m_lat) begin
                e_hi = p_hi; e_lo = p_lo; e_zero = p_zero; e_div0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit own;
            own = m_active && (m_lat == 17) && (m_age <= 16);
            check("busy",    bus.busy,    m_active);
            check("done",    bus.done,    m_active && (m_age == m_lat));
            check("alu_own", bus.alu_own, own);
            check("alu_op",  bus.alu_op,  own ? (m_cmd ? ALU_SUB : ALU_ADD) : ALU_MOV);
            check("alu_a",   bus.alu_a,   own ? (m_cmd ? m_b : m_a) : 16'h0);
            if (!own) check("alu_b", bus.alu_b, 16'h0);
            check("shift_d", bus.alu_shift_d, 4'd0);
            check("res_hi",  bus.res_hi,  e_hi);
            check("res_lo",  bus.res_lo,  e_lo);
            check("zero",    bus.zero,    e_zero);
            check("div0",    bus.div0,    e_div0);
        end
    end

    // Called at a negedge in IDLE; returns at the negedge where done is seen.
    task automatic do_op(input bit c, input logic [15:0] a, input logic [15:0] b,
                         input int inj, output int lat, output bit own_seen,
                         output logic [15:0] hi, output logic [15:0] lo,
                         output bit z, output bit d0);
        bus.start = 1'b1; bus.cmd = c; bus.opa = a; bus.opb = b;
        lat = 0; own_seen = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (n == inj) begin
                bus.start = 1'b1; bus.cmd = ~c;
                bus.opa = 16'($urandom); bus.opb = 16'($urandom);
            end
            if (bus.alu_own) own_seen = 1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        hi = bus.res_hi; lo = bus.res_lo; z = bus.zero; d0 = bus.div0;
        check("latency", lat, (c && b == 16'h0) ? 1 : 17);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit own_seen, z, d0;
        logic [15:0] hi, lo;
        bit c;
        logic [15:0] a, b;
        int inj;

        bus.start = 0; bus.cmd = 0; bus.opa = '0; bus.opb = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_op",   bus.alu_op, 4'b0110);
        check("rst_lo",   bus.res_lo, 16'h0);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 16'h1234, 16'h5678, -1, lat, own_seen, hi, lo, z, d0);
        check("mul1_lat", lat, 17);
        check("mul1_hi", hi, 16'h0626);
        check("mul1_lo", lo, 16'h0060);
        check("mul1_zero", z, 1'b0);
        @(negedge clk);

        do_op(0, 16'hFFFF, 16'hFFFF, -1, lat, own_seen, hi, lo, z, d0);
        check("mul2_hi", hi, 16'hFFFE);
        check("mul2_lo", lo, 16'h0001);
        @(negedge clk);
        do_op(0, 16'h0000, 16'hABCD, -1, lat, own_seen, hi, lo, z, d0);
        check("mul3_res", {hi, lo}, 32'h0);
        check("mul3_zero", z, 1'b1);
        @(negedge clk);

        do_op(1, 16'hFFFF, 16'h0010, -1, lat, own_seen, hi, lo, z, d0);
        check("div1_q", lo, 16'h0FFF);
        check("div1_r", hi, 16'h000F);
        @(negedge clk);
        do_op(1, 16'h0005, 16'h0007, -1, lat, own_seen, hi, lo, z, d0);
        check("div2_q", lo, 16'h0000);
        check("div2_r", hi, 16'h0005);
        check("div2_zero", z, 1'b1);
        @(negedge clk);

        do_op(1, 16'h1234, 16'h0000, -1, lat, own_seen, hi, lo, z, d0);
        check("div0_lat", lat, 1);
        check("div0_q", lo, 16'hFFFF);
        check("div0_r", hi, 16'h1234);
        check("div0_flag", d0, 1'b1);
        check("div0_own", own_seen, 1'b0);
        @(negedge clk);

        // Start during ITER ignored; start in the cycle after done accepted.
        do_op(0, 16'h0101, 16'h0202, 5, lat, own_seen, hi, lo, z, d0);
        check("ign_hi", hi, 16'h0002);
        check("ign_lo", lo, 16'h0402);
        @(negedge clk);
        do_op(1, 16'h8000, 16'h0003, -1, lat, own_seen, hi, lo, z, d0);
        check("back_q", lo, 16'h2AAA);
        check("back_r", hi, 16'h0002);
        @(negedge clk);

        // Reset in ITER cycle 8 aborts the operation.
        bus.start = 1'b1; bus.cmd = 0; bus.opa = 16'h00FF; bus.opb = 16'h0F0F;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_own",  bus.alu_own, 1'b0);
        check("abort_done", bus.done, 1'b0);
        check("abort_res",  {bus.res_hi, bus.res_lo}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        do_op(0, 16'h0003, 16'h0005, -1, lat, own_seen, hi, lo, z, d0);
        check("post_rst_lo", lo, 16'h000F);
        check("post_rst_hi", hi, 16'h0000);
        @(negedge clk);

        for (int k = 0; k < 150; k++) begin
            c = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 9) == 0) b = 16'h0;
            else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 3));
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : -1;
            do_op(c, a, b, inj, lat, own_seen, hi, lo, z, d0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
